// File: rtl/survivor_traceback.sv
// Viterbi survivor-path traceback: stores one decision vector per trellis stage
// during FILL, then walks the survivor path backwards emitting one decoded bit per stage.
module survivor_traceback #(
  parameter  int K       = 3,
  parameter  int DEPTH   = 8,
  localparam int STATE_W = K - 1,
  localparam int NUM_ST  = 1 << STATE_W,
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUM_ST-1:0]  in_dec,
  input  logic               in_last,
  input  logic [STATE_W-1:0] in_best_st,
  input  logic               tb_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_bit,
  output logic [PTR_W-1:0]   out_stage,
  output logic               out_last
);

  typedef enum logic {FILL, TRACE} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [STATE_W-1:0] cur_st_q, cur_st_d;
  logic               wr_en;

  logic [NUM_ST-1:0]  mem [DEPTH];

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cur_st_d = cur_st_q;
    wr_en    = 1'b0;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          wr_en = 1'b1;
          // Frame closes on in_last or when the last memory row is written.
          if (in_last || (wr_ptr_q == PTR_W'(DEPTH - 1))) begin
            state_d  = TRACE;
            rd_ptr_d = wr_ptr_q;
            cur_st_d = tb_mode ? in_best_st : '0;
            wr_ptr_d = '0;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end
        end
      end
      TRACE: begin
        if (out_ready) begin
          // Predecessor state: shift in the survivor decision of the current state.
          cur_st_d = {cur_st_q[STATE_W-2:0], mem[rd_ptr_q][cur_st_q]};
          if (rd_ptr_q == '0) begin
            state_d = FILL;
          end else begin
            rd_ptr_d = rd_ptr_q - PTR_W'(1);
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cur_st_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cur_st_q <= cur_st_d;
    end
  end

  // NOTE: decision memory has no reset; each stage is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= in_dec;
    end
  end

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == TRACE);
  assign out_bit   = out_valid & cur_st_q[STATE_W-1];
  assign out_stage = rd_ptr_q;
  assign out_last  = out_valid & (rd_ptr_q == '0);

endmodule
